// File: rtl/uart_rx.sv
// UART receiver with OV_SAMP-times oversampling driven by a shared baud-tick
// enable. Start bits are validated at mid-bit; data, parity and stop bits are
// sampled at bit centres. Each finished character is presented with its error
// flags alongside a one-cycle done strobe that writes the RX FIFO.
module uart_rx #(
   parameter int unsigned OV_SAMP = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_baud,
   input  logic       i_rx_en,
   input  logic       i_rx,
   input  logic [2:0] i_parity_sel,
   input  logic       i_stop_sel,
   input  logic [1:0] i_width_sel,
   output logic [7:0] o_data,
   output logic       o_rx_done,
   output logic       o_parity_err,
   output logic       o_frame_err,
   output logic       o_break
);

   // Tick counter is 4 bits wide, so OV_SAMP is limited to 4..16 (even).
   localparam logic [3:0] MID_M1  = 4'(OV_SAMP / 2 - 1);
   localparam logic [3:0] LAST_TK = 4'(OV_SAMP - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_PARITY  = 3'd3;
   localparam logic [2:0] S_STOP_I  = 3'd4;
   localparam logic [2:0] S_STOP_II = 3'd5;

   // Line synchroniser and edge-detect history.
   logic       sync1_q, rx_s_q, prev_q;

   // Frame state.
   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       xor_q, xor_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       brk_q, brk_d;

   // Output register, updated only when a frame completes.
   logic [7:0] out_data_q, out_data_d;
   logic       out_perr_q, out_perr_d;
   logic       out_ferr_q, out_ferr_d;
   logic       out_brk_q, out_brk_d;
   logic       done_q, done_d;

   logic       fall_edge;
   logic       bit_tick;
   logic [2:0] last_idx;
   logic       par_exp;
   logic       ferr_n;
   logic       brk_n;

   assign fall_edge = prev_q & ~rx_s_q;
   assign bit_tick  = i_baud && (cnt_q == LAST_TK);
   assign last_idx  = {1'b0, i_width_sel} + 3'd4;
   // Stick parity uses bit0 directly; otherwise even/odd over the data bits.
   assign par_exp   = i_parity_sel[1] ? i_parity_sel[0] : (xor_q ^ i_parity_sel[0]);
   assign ferr_n    = ferr_q | ~rx_s_q;
   assign brk_n     = brk_q & ~rx_s_q;

   // Next-state logic for the frame FSM and its datapath.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      xor_d      = xor_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      out_data_d = out_data_q;
      out_perr_d = out_perr_q;
      out_ferr_d = out_ferr_q;
      out_brk_d  = out_brk_q;
      done_d     = 1'b0;

      // Free-running oversample counter while a frame is in progress.
      if (state_q != S_IDLE && i_baud) begin
         cnt_d = (cnt_q == LAST_TK) ? 4'd0 : cnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            idx_d = 3'd0;
            if (i_rx_en && fall_edge) begin
               state_d = S_START;
               shift_d = 8'h00;
               xor_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               brk_d   = 1'b1;
            end
         end

         S_START: begin
            if (i_baud && cnt_q == MID_M1) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;      // glitch, not a start bit
               end else begin
                  cnt_d   = 4'd0;        // realign to bit centres
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (bit_tick) begin
               shift_d[idx_q] = rx_s_q;
               xor_d          = xor_q ^ rx_s_q;
               brk_d          = brk_n;
               if (idx_q == last_idx) begin
                  state_d = i_parity_sel[2] ? S_PARITY : S_STOP_I;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         S_PARITY: begin
            if (bit_tick) begin
               perr_d  = (rx_s_q != par_exp);
               brk_d   = brk_n;
               state_d = S_STOP_I;
            end
         end

         S_STOP_I: begin
            if (bit_tick) begin
               ferr_d = ferr_n;
               brk_d  = brk_n;
               if (i_stop_sel) begin
                  state_d = S_STOP_II;
               end else begin
                  state_d    = S_IDLE;
                  done_d     = 1'b1;
                  out_data_d = shift_q;
                  out_perr_d = perr_q;
                  out_ferr_d = ferr_n;
                  out_brk_d  = brk_n;
               end
            end
         end

         S_STOP_II: begin
            if (bit_tick) begin
               ferr_d     = ferr_n;
               state_d    = S_IDLE;
               done_d     = 1'b1;
               out_data_d = shift_q;
               out_perr_d = perr_q;
               out_ferr_d = ferr_n;
               out_brk_d  = brk_q;      // break looks only at the first stop bit
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Synchroniser, edge history and state registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (i_rst) begin
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= 3'd0;
         shift_q    <= 8'h00;
         xor_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         out_data_q <= 8'h00;
         out_perr_q <= 1'b0;
         out_ferr_q <= 1'b0;
         out_brk_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         sync1_q    <= i_rx;
         rx_s_q     <= sync1_q;
         // Tracks in every state so a start edge right after the stop sample
         // is still seen when the FSM returns to IDLE.
         prev_q     <= rx_s_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         xor_q      <= xor_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         out_data_q <= out_data_d;
         out_perr_q <= out_perr_d;
         out_ferr_q <= out_ferr_d;
         out_brk_q  <= out_brk_d;
         done_q     <= done_d;
      end
   end

   assign o_data       = out_data_q;
   assign o_rx_done    = done_q;
   assign o_parity_err = out_perr_q;
   assign o_frame_err  = out_ferr_q;
   assign o_break      = out_brk_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver with 16x oversampling, driven by the shared baud-tick enable. It resynchronises the serial input, validates the start bit at mid-bit, and samples 5-8 data bits, an optional parity bit and 1 or 2 stop bits at bit centres. It writes each completed character, with its error flags, into the RX FIFO using a one-cycle done pulse. Line-format controls use the same encodings as the UART transmitter, so both ends share the same configuration register fields.

Parameters:
OV_SAMP, 16, i_baud ticks per bit. Must be an even number, at least 4 and at most 16; the tick counter is 4 bits.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset; synchronous, active-high
i_baud  input  1  one-cycle enable at OV_SAMP x baud rate
i_rx_en  input  1  enables reception of new frames
i_rx  input  1  serial line, asynchronous to i_clk
i_parity_sel  input  3  bit2 enables parity; bit1 selects stick parity; bit0 selects odd (1) or even (0), or is the stick value when bit1=1
i_stop_sel  input  1  0 = 1 stop bit, 1 = 2 stop bits
i_width_sel  input  2  00/01/10/11 = 5/6/7/8 data bits
o_data  output  8  received character, LSB first, right-aligned, unused upper bits 0
o_rx_done  output  1  one-cycle pulse; write strobe to the RX FIFO
o_parity_err  output  1  parity mismatch for the character in o_data
o_frame_err  output  1  a stop bit was sampled low
o_break  output  1  break: all data bits 0, parity bit 0 (if enabled), first stop bit 0

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE, tick counter 0, bit index 0, synchroniser and previous-sample registers set to 1, all outputs 0.
- Input sync: two-flop synchroniser on i_rx gives rx_s. rx_s lags i_rx by 2 cycles. All decisions use rx_s.
- Tick counter (4 bit) advances only on cycles where i_baud=1. MID = OV_SAMP/2.
- States: IDLE, START, DATA, PARITY, STOP_I, STOP_II.
- IDLE: go to START when i_rx_en=1 and rx_s shows a falling edge (previous rx_s = 1, current = 0). Counter and index cleared. A line held low does not retrigger; a new 1-to-0 edge is required.
- START: on the i_baud tick where counter = MID-1, sample rx_s.
  - rx_s = 1: false start; return to IDLE with no flags and no pulse.
  - rx_s = 0: counter cleared, go to DATA. Samples are now aligned to bit centres.
- DATA: on the i_baud tick where counter = OV_SAMP-1, store rx_s into shift[index] and fold it into the running parity XOR.
  - After the last bit (index = width-1), go to PARITY if i_parity_sel[2]=1, else STOP_I.
  - Bits above the selected width are cleared at frame start.
- PARITY: sample at counter = OV_SAMP-1.
  - Expected value: i_parity_sel[0] when stick (bit1=1); otherwise XOR(data) ^ i_parity_sel[0].
  - Record a mismatch. Go to STOP_I.
- STOP_I: sample at counter = OV_SAMP-1; a low sample sets the pending frame error.
  - i_stop_sel=0: complete the frame and go to IDLE.
  - i_stop_sel=1: go to STOP_II.
- STOP_II: sample at counter = OV_SAMP-1; a low sample sets the pending frame error. Complete the frame and go to IDLE.
- Frame completion: in the cycle after the final stop sample, o_rx_done=1 for exactly one cycle.
  - o_data, o_parity_err, o_frame_err and o_break update in that same cycle.
  - These outputs then hold until the next completion or reset.
  - Completion also occurs for frames with errors.
- Back-to-back frames: the IDLE edge detector is live in the cycle after completion. A start edge arriving during the second half of the last stop bit must be caught; the previous-sample register keeps tracking rx_s in every state for this reason.
- i_rx_en is checked only in IDLE. Deasserting it mid-frame lets the current frame finish normally.
- Config inputs must be static while a frame is in progress; behaviour is undefined if they change mid-frame.
- Reset mid-frame: returns to IDLE immediately, with no done pulse and all flags cleared.
- Undefined state encodings go to IDLE.
- No internal data buffering beyond the output register. FIFO overflow is the FIFO's responsibility.

Test Plan:
1. 8N1, i_rx driven with 0xA5 at 16 ticks/bit -> one o_rx_done pulse, o_data=0xA5, all error flags 0.
2. 7 bits, even parity (sel=100), character 0x35 with parity bit 0 -> o_data=0x35, o_parity_err=0. Repeat with parity bit 1 -> o_parity_err=1, o_data=0x35.
3. 5 bits, 2 stop bits, stick-1 parity (sel=111), 0x1F sent back-to-back twice with no idle gap -> two done pulses, each o_data=0x1F, no errors.
4. Glitch: i_rx low for 3 ticks, then high -> returns to IDLE, no o_rx_done. A following valid 0x00 frame with stop=1 -> o_data=0x00, o_break=0.
5. 8N1, line held low for 20 bit times -> a single done pulse with o_data=0x00, o_frame_err=1, o_break=1. No further frames until i_rx rises and then falls again.
6. Reset asserted mid-DATA of 0x5A, released, then 0xC3 sent -> no pulse for the aborted frame; o_data=0xC3 with no errors. Also, i_rx_en=0 with a valid frame -> no pulse.
